// File: rtl/input_mems_pp_pkg.sv
// Shared types for the double-buffered matrix input memories.
package input_mems_pkg;
  localparam int SLOT_K_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} load_state_t;

  typedef struct packed {
    logic                valid;
    logic [SLOT_K_W-1:0] k;
    logic                a_sel;
  } slot_t;
endpackage

// File: rtl/input_mems_pp_if.sv
// AXI-stream style word interface feeding the matrix loader.
interface input_mems_pp_if
  import input_mems_pkg::*;
#(
  parameter int INW    = 12,
  parameter int K_BITS = 4
);
  logic signed [INW-1:0] AXIS_TDATA;
  logic                  AXIS_TVALID;
  logic [K_BITS:0]       AXIS_TUSER;
  logic                  AXIS_TREADY;

  modport master (output AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, input AXIS_TREADY);
  modport slave  (input AXIS_TDATA, AXIS_TVALID, AXIS_TUSER, output AXIS_TREADY);
endinterface

// File: rtl/input_mems_pp_mem.sv
// Single-port synchronous RAM: one address shared by write and registered read.
module input_mems_pp_mem #(
  parameter int W     = 12,
  parameter int DEPTH = 56,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic signed [W-1:0] wdata,
  output logic signed [W-1:0] rdata
);
  logic signed [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/input_mems_pp.sv
// Ping-pong A/B matrix store: a streaming loader fills one set slot while the
// compute side reads the other; A banks can be shared between consecutive sets.
module input_mems_pp
  import input_mems_pkg::*;
#(
  parameter int  INW         = 12,
  parameter int  M           = 7,
  parameter int  N           = 9,
  parameter int  MAXK        = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input_mems_pp_if.slave         axis,
  output logic                   matrices_loaded,
  input  logic                   compute_finished,
  output logic [K_BITS-1:0]      K,
  input  logic [A_ADDR_BITS-1:0] A_read_addr,
  input  logic [B_ADDR_BITS-1:0] B_read_addr,
  output logic signed [INW-1:0]  A_data,
  output logic signed [INW-1:0]  B_data,
  output logic                   load_error
);
  localparam int CNT_W = (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

  load_state_t           state;
  slot_t                 slot [2];
  logic                  wr_ptr, rd_ptr, last_a, a_sel_r;
  logic [K_BITS-1:0]     k_r;
  logic [CNT_W-1:0]      cnt;
  logic                  axis_ready;
  logic                  a_sel_p1, b_sel_p1;

  logic                  new_a, k_bad, a_conflict, hs, first, first_ok;
  logic [K_BITS-1:0]     k_in;
  logic [CNT_W-1:0]      lim_a, lim_b;
  logic                  a_wr, b_wr, a_wbank;
  logic [1:0]            a_we, b_we;
  logic [A_ADDR_BITS-1:0] a_addr [2];
  logic [B_ADDR_BITS-1:0] b_addr [2];
  logic signed [INW-1:0] a_rdata [2];
  logic signed [INW-1:0] b_rdata [2];

  assign new_a      = axis.AXIS_TUSER[0];
  assign k_in       = axis.AXIS_TUSER[K_BITS:1];
  assign k_bad      = (k_in == '0) || (k_in > K_BITS'(MAXK));
  // A new-A load overwrites bank ~last_a, so it must wait while any held set still reads it.
  assign a_conflict = (slot[0].valid && (slot[0].a_sel == ~last_a)) ||
                      (slot[1].valid && (slot[1].a_sel == ~last_a));

  always_comb begin
    axis_ready = 1'b1;
    if (state == IDLE) axis_ready = !slot[wr_ptr].valid && !(new_a && a_conflict);
  end

  assign axis.AXIS_TREADY = reset_n && axis_ready;
  assign hs       = axis.AXIS_TVALID && axis.AXIS_TREADY;
  assign first    = hs && (state == IDLE);
  assign first_ok = first && !k_bad;
  assign lim_a    = CNT_W'(M) * CNT_W'(k_r) - CNT_W'(1);
  assign lim_b    = CNT_W'(N) * CNT_W'(k_r) - CNT_W'(1);

  assign a_wr    = (first_ok && new_a) || (hs && (state == LOAD_A));
  assign b_wr    = (first_ok && !new_a) || (hs && (state == LOAD_B));
  assign a_wbank = (state == IDLE) ? ~last_a : a_sel_r;

  for (genvar j = 0; j < 2; j++) begin : g_bank
    assign a_we[j]   = a_wr && (a_wbank == 1'(j));
    assign b_we[j]   = b_wr && (wr_ptr == 1'(j));
    assign a_addr[j] = a_we[j] ? cnt[A_ADDR_BITS-1:0] : A_read_addr;
    assign b_addr[j] = b_we[j] ? cnt[B_ADDR_BITS-1:0] : B_read_addr;

    input_mems_pp_mem #(.W(INW), .DEPTH(M * MAXK), .AW(A_ADDR_BITS)) u_a (
      .clk(clk), .we(a_we[j]), .addr(a_addr[j]), .wdata(axis.AXIS_TDATA), .rdata(a_rdata[j])
    );
    input_mems_pp_mem #(.W(INW), .DEPTH(MAXK * N), .AW(B_ADDR_BITS)) u_b (
      .clk(clk), .we(b_we[j]), .addr(b_addr[j]), .wdata(axis.AXIS_TDATA), .rdata(b_rdata[j])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      slot[0]    <= '0;
      slot[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      last_a     <= 1'b1;
      a_sel_r    <= 1'b0;
      k_r        <= '0;
      cnt        <= '0;
      load_error <= 1'b0;
    end else begin
      load_error <= first && k_bad;
      if (compute_finished && slot[rd_ptr].valid) begin
        slot[rd_ptr].valid <= 1'b0;
        rd_ptr             <= ~rd_ptr;
      end
      case (state)
        IDLE: if (first_ok) begin
          k_r     <= k_in;
          a_sel_r <= new_a ? ~last_a : last_a;
          cnt     <= CNT_W'(1);
          state   <= new_a ? LOAD_A : LOAD_B;
        end
        LOAD_A: if (hs) begin
          if (cnt == lim_a) begin
            cnt   <= '0;
            state <= LOAD_B;
          end else cnt <= cnt + CNT_W'(1);
        end
        LOAD_B: if (hs) begin
          if (cnt == lim_b) begin
            slot[wr_ptr] <= '{valid: 1'b1, k: SLOT_K_W'(k_r), a_sel: a_sel_r};
            wr_ptr       <= ~wr_ptr;
            last_a       <= a_sel_r;
            cnt          <= '0;
            state        <= IDLE;
          end else cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- read stage p1: bank selects follow the addresses by one cycle ----
  always_ff @(posedge clk) begin
    a_sel_p1 <= slot[rd_ptr].a_sel;
    b_sel_p1 <= rd_ptr;
  end

  assign A_data          = a_rdata[a_sel_p1];
  assign B_data          = b_rdata[b_sel_p1];
  assign matrices_loaded = slot[rd_ptr].valid;
  assign K               = slot[rd_ptr].valid ? K_BITS'(slot[rd_ptr].k) : '0;
endmodule

// File: tb/tb_input_mems_pp.sv
// Directed bench for input_mems_pp with a read-data scoreboard.
module tb_input_mems_pp;
  localparam int INW = 12, M = 7, N = 9, MAXK = 8;
  localparam int K_BITS = 4, AAB = 6, BAB = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_n = 1'b0;
  logic                  compute_finished = 1'b0;
  logic [AAB-1:0]        A_read_addr = '0;
  logic [BAB-1:0]        B_read_addr = '0;
  logic                  matrices_loaded, load_error;
  logic [K_BITS-1:0]     K;
  logic signed [INW-1:0] A_data, B_data;

  input_mems_pp_if #(.INW(INW), .K_BITS(K_BITS)) axis ();

  input_mems_pp #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
    .clk(clk), .reset_n(reset_n), .axis(axis), .matrices_loaded(matrices_loaded),
    .compute_finished(compute_finished), .K(K), .A_read_addr(A_read_addr),
    .B_read_addr(B_read_addr), .A_data(A_data), .B_data(B_data), .load_error(load_error)
  );

  int n_vec = 0, n_bad = 0, hs_cnt = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string nm;
    int    ea;
    int    eb;
    bit    ca;
    bit    cb;
  } rd_t;
  rd_t  sb [$];
  logic rd_req = 1'b0, req_p1 = 1'b0;

  always @(posedge clk) req_p1 <= rd_req;

  always @(negedge clk) begin : monitor
    rd_t e;
    if (axis.AXIS_TVALID && axis.AXIS_TREADY) hs_cnt++;
    if (req_p1 === 1'b1) begin
      if (sb.size() == 0) chk("scoreboard_underflow", 0, 1);
      else begin
        e = sb.pop_front();
        if (e.ca) chk({e.nm, "_A"}, int'(A_data), e.ea);
        if (e.cb) chk({e.nm, "_B"}, int'(B_data), e.eb);
      end
    end
  end

  task automatic rd(string nm, int aa, int ba, int ea, int eb);
    A_read_addr = AAB'(aa);
    B_read_addr = BAB'(ba);
    sb.push_back('{nm, ea, eb, 1'b1, 1'b1});
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic send(int d, int user);
    int t = 0;
    axis.AXIS_TDATA  = INW'(d);
    axis.AXIS_TUSER  = (K_BITS + 1)'(user);
    axis.AXIS_TVALID = 1'b1;
    @(negedge clk);
    while (!axis.AXIS_TREADY && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (t >= 300) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    axis.AXIS_TVALID = 1'b0;
  endtask

  // Streams a whole set; with skip_last the final B word is left to the caller.
  task automatic send_set(int newa, int k, int abase, int bbase, bit skip_last);
    int na = newa ? M * k : 0;
    int tot = na + k * N;
    for (int i = 0; i < tot - (skip_last ? 1 : 0); i++)
      send(i < na ? abase + 1 + i : bbase + 1 + i - na, i == 0 ? k * 2 + newa : 0);
  endtask

  task automatic release_set();
    compute_finished = 1'b1;
    @(posedge clk); #1;
    compute_finished = 1'b0;
  endtask

  task automatic status(string nm, int exp_loaded, int exp_k);
    @(negedge clk);
    chk({nm, "_loaded"}, int'(matrices_loaded), exp_loaded);
    chk({nm, "_K"}, int'(K), exp_k);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs_base;
    axis.AXIS_TVALID = 1'b0;
    axis.AXIS_TDATA  = '0;
    axis.AXIS_TUSER  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready", int'(axis.AXIS_TREADY), 0);
    chk("reset_loaded", int'(matrices_loaded), 0);
    chk("reset_K", int'(K), 0);
    chk("reset_load_error", int'(load_error), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("tready_after_reset", int'(axis.AXIS_TREADY), 1);
    @(posedge clk); #1;

    // Set 1: new A, K=4
    send_set(1, 4, 0, 100, 1'b1);
    status("s1_before_last", 0, 0);
    send(136, 0);
    status("s1_done", 1, 4);
    rd("s1_a27_b35", 27, 35, 28, 136);
    rd("s1_a0_b0", 0, 0, 1, 101);

    // Set 2 reuses A while set 1 is held
    send_set(0, 4, 0, 200, 1'b0);
    status("s1_still_current", 1, 4);

    // Set 3 first word must stall until set 1 is released
    axis.AXIS_TDATA  = INW'(301);
    axis.AXIS_TUSER  = (K_BITS + 1)'(3);
    axis.AXIS_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tready_both_full", int'(axis.AXIS_TREADY), 0);
    end
    @(posedge clk); #1;
    release_set();
    status("s2_current", 1, 4);
    axis.AXIS_TVALID = 1'b0;
    for (int i = 2; i <= 7; i++) send(300 + i, 0);
    for (int i = 1; i <= 9; i++) send(310 + i, 0);
    rd("s2_a27_b35", 27, 35, 28, 236);
    rd("s2_a0_b0", 0, 0, 1, 201);

    // Set 4 new A: its bank is still read by set 2, so it stalls until release
    axis.AXIS_TDATA  = INW'(401);
    axis.AXIS_TUSER  = (K_BITS + 1)'(3);
    axis.AXIS_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tready_a_bank_busy", int'(axis.AXIS_TREADY), 0);
    end
    @(posedge clk); #1;
    hs_base = hs_cnt;
    release_set();
    @(posedge clk); #1;
    axis.AXIS_TVALID = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      send(i <= 7 ? 400 + i : 410 + i - 7, 0);
      @(posedge clk); #1;
    end
    chk("s4_handshakes", hs_cnt - hs_base, 16);
    status("s3_current", 1, 1);
    rd("s3_a6_b8", 6, 8, 307, 319);
    rd("s3_a0_b0", 0, 0, 301, 311);
    release_set();
    status("s4_current", 1, 1);
    rd("s4_a3_b8", 3, 8, 404, 419);
    rd("s4_a0_b0", 0, 0, 401, 411);
    release_set();
    status("all_released", 0, 0);
    release_set();
    status("spurious_release", 0, 0);

    // Illegal K is swallowed with a single-cycle error pulse
    send(900, 9 * 2 + 1);
    @(negedge clk);
    chk("load_error_pulse", int'(load_error), 1);
    chk("idle_after_error", int'(axis.AXIS_TREADY), 1);
    @(negedge clk);
    chk("load_error_clear", int'(load_error), 0);
    @(posedge clk); #1;
    send_set(0, 1, 0, 610, 1'b0);
    status("s6_done", 1, 1);
    rd("s6_a3_b8", 3, 8, 404, 619);
    release_set();

    // Reset in the middle of a K=8 load
    for (int i = 0; i < 10; i++) send(700 + i, i == 0 ? 17 : 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midload_reset_tready", int'(axis.AXIS_TREADY), 0);
    chk("midload_reset_loaded", int'(matrices_loaded), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_set(1, 2, 500, 520, 1'b1);
    status("s7_before_last", 0, 0);
    send(538, 0);
    status("s7_done", 1, 2);
    rd("s7_a13_b17", 13, 17, 514, 538);
    rd("s7_a0_b0", 0, 0, 501, 521);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/input_mems_pp.md
INPUT_MEMS_PP -- requirements
Module: input_mems_pp

Interface
REQ-001 Parameter INW, default 12: element width in bits, signed.
REQ-002 Parameter M, default 7: rows of A.
REQ-003 Parameter N, default 9: columns of B.
REQ-004 Parameter MAXK, default 8: maximum shared dimension K; K_BITS=$clog2(MAXK+1), A_ADDR_BITS=$clog2(M*MAXK), B_ADDR_BITS=$clog2(MAXK*N).
REQ-005 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port AXIS_TDATA, input, INW: stream element.
REQ-008 Port AXIS_TVALID, input, 1: source has data.
REQ-009 Port AXIS_TUSER, input, K_BITS+1: bit 0 is new_A; bits K_BITS:1 are K; sampled only on the first word of a set.
REQ-010 Port AXIS_TREADY, output, 1: block accepts a word this cycle.
REQ-011 Port matrices_loaded, output, 1: a complete set is available to compute.
REQ-012 Port compute_finished, input, 1: one-cycle pulse releasing the current set.
REQ-013 Port K, output, K_BITS: K of the current set.
REQ-014 Ports A_read_addr (A_ADDR_BITS) and B_read_addr (B_ADDR_BITS), input: read addresses.
REQ-015 Ports A_data and B_data, output, signed INW: read data.
REQ-016 Port load_error, output, 1: one-cycle pulse when an illegal first word is dropped.

Function
REQ-017 Storage SHALL be two A banks (M*MAXK words each) and two B banks (MAXK*N words each), giving two set slots 0 and 1.
REQ-018 Each slot SHALL hold valid, K and a_sel; slot i uses B bank i and A bank a_sel.
REQ-019 A handshake SHALL be AXIS_TVALID & AXIS_TREADY in the same cycle; only handshakes advance counters.
REQ-020 Loader states SHALL be IDLE, LOAD_A, LOAD_B.
REQ-021 IDLE: AXIS_TREADY=1 only when slot[wr_ptr] is invalid and, if new_A=1, no valid slot has a_sel equal to ~last_a.
REQ-022 First-word handshake in IDLE: latch K, and set the target A bank to ~last_a if new_A=1 or to last_a if new_A=0.
REQ-023 First-word handshake, continued: write the word at address 0 and go to LOAD_A if new_A=1, or LOAD_B if new_A=0.
REQ-024 LOAD_A SHALL write M*K words at addresses 0..M*K-1; the last one goes to LOAD_B with the address counter at 0.
REQ-025 LOAD_B SHALL write K*N words at addresses 0..K*N-1.
REQ-026 On the last B handshake: set slot[wr_ptr] valid with K and a_sel, toggle wr_ptr, update last_a to a_sel, and return to IDLE.
REQ-027 AXIS_TREADY SHALL be 1 throughout LOAD_A and LOAD_B (the target slot is already reserved).
REQ-028 A first word with K=0 or K>MAXK SHALL be accepted and discarded; load_error pulses the next cycle and the loader stays in IDLE.
REQ-029 matrices_loaded SHALL equal slot[rd_ptr].valid, asserted the cycle after the final B handshake.
REQ-030 K SHALL equal slot[rd_ptr].K, and SHALL be 0 when no slot is valid.
REQ-031 A_data and B_data SHALL have 1-cycle read latency, from A bank slot[rd_ptr].a_sel and B bank rd_ptr.
REQ-032 compute_finished with matrices_loaded=1 SHALL clear slot[rd_ptr].valid and toggle rd_ptr; with matrices_loaded=0 it SHALL be ignored.
REQ-033 A release and a load completion in the same cycle SHALL both take effect.
REQ-034 A new_A=0 set loaded before any A SHALL use bank last_a, with undefined contents.

Reset
REQ-035 While reset_n=0: state IDLE, both slots invalid, wr_ptr=rd_ptr=0, last_a=1, counters 0.
REQ-036 While reset_n=0: AXIS_TREADY=0, matrices_loaded=0, K=0, load_error=0; A_data and B_data are don't-care until the first read.
REQ-037 AXIS_TREADY SHALL be 1 in the first cycle after reset_n rises.
REQ-038 Reset mid-load SHALL abandon the partial set; memory contents are not cleared.

Structure
REQ-039 Package input_mems_pkg SHALL hold the loader-state enum and the slot struct typedef.
REQ-040 The existing single-port memory sub-module SHALL be instantiated four times.

Verification
REQ-041 Set 1, new_A=1, K=4: A=1..28, B=101..136 -> matrices_loaded=1 the cycle after word 64; K=4; A_read_addr=27 -> A_data=28; B_read_addr=35 -> B_data=136.
REQ-042 During set 1 compute: set 2, new_A=0, K=4 loads fully; a third first word sees TREADY=0 until compute_finished, then set 2 reads A_data=28 at address 27.
REQ-043 While a slot uses A bank ~last_a, a new_A=1 first word -> TREADY=0 until that slot is released.
REQ-044 TVALID toggling every other cycle with K=1 -> exactly 16 handshakes complete the set; words are stored in order.
REQ-045 reset_n low after 10 words of a K=8 set, then a fresh K=2 new_A=1 set -> matrices_loaded only after 32 words, with K=2.
REQ-046 First word with K=9 -> load_error=1 for one cycle; the next legal set loads normally.
